mem_stage_pipe: RTL
===================

MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning datapath, address and store/load width.
REQ-002 SHALL have parameter DEST_W, default 3, meaning destination register index width.
REQ-003 SHALL have parameter OPC_W, default 4, meaning opcode width.
REQ-004 SHALL have ports as follows; clk and rst_n come first, and rst_n is the asynchronous, active-low reset.
- clk  in  1  sole clock; all state is updated on the rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX bundle valid
- ex_opcode  in  OPC_W  opcode
- ex_alu_res  in  DATA_W  ALU result / memory address
- ex_store_data  in  DATA_W  store data
- ex_op_dest  in  DEST_W  destination register
- ex_mem_rd, ex_mem_wr  in  1  load / store request
- ex_wb_mux, ex_wb_en  in  1  writeback select / enable
- stall_o  out  1  upstream hold
- dmem_req, dmem_we  out  1  memory request / write
- dmem_addr, dmem_wdata  out  DATA_W  memory address / write data
- dmem_rdata  in  DATA_W  memory read data
- dmem_ack  in  1  access complete
- mem_valid, mem_wb_mux, mem_wb_en  out  1  registered MEM/WB control
- mem_op_dest  out  DEST_W  registered destination
- mem_alu_res, mem_mem_data  out  DATA_W  registered results
- opcode_mem_wb  out  OPC_W  registered opcode

Function
REQ-005 SHALL implement FSM IDLE/ACCESS; stall_o = (state==ACCESS), combinational.
REQ-006 In IDLE with ex_valid=1 and ex_mem_rd=ex_mem_wr=0, the block SHALL load all mem_* registers from ex_* on the next edge with mem_valid=1 and mem_mem_data=0 (1-cycle latency).
REQ-007 In IDLE with ex_valid=1 and ex_mem_rd|ex_mem_wr, the block SHALL capture the EX bundle and enter ACCESS; on that edge mem_valid=0 and mem_wb_en=0.
REQ-008 In ACCESS, dmem_req SHALL be 1, and dmem_addr/dmem_wdata/dmem_we SHALL be driven from the captured bundle and held stable until dmem_ack.
REQ-009 If ex_mem_rd and ex_mem_wr are both set, the access SHALL be a write (dmem_we=1).
REQ-010 On ACCESS with dmem_ack=1, the block SHALL return to IDLE and register captured fields with mem_valid=1; loads set mem_mem_data=dmem_rdata, stores set mem_mem_data=0 and mem_wb_en=0.
REQ-011 The stall_o=1 held during the ack cycle SHALL enforce one bubble per memory op; the next op is accepted in the following IDLE cycle.
REQ-012 In IDLE with ex_valid=0, the block SHALL set mem_valid=0 and mem_wb_en=0 and hold the other mem_* outputs.
REQ-013 ACCESS with no dmem_ack SHALL wait indefinitely; dmem_ack outside ACCESS SHALL be ignored.
REQ-014 A memory op SHALL reach mem_valid at the edge after the dmem_ack cycle; minimum latency is 2 cycles.

Reset
REQ-015 rst_n=0 SHALL asynchronously force state IDLE and all registered outputs to 0, dropping dmem_req immediately, including mid-ACCESS; the aborted op SHALL never produce mem_valid.
REQ-016 The first edge after rst_n deasserts SHALL process normally.

Configuration
REQ-017 With MEM_STAGE_FWD_EN defined, the block SHALL add outputs fwd_valid (1) = mem_valid&mem_wb_en, fwd_dest (DEST_W) = mem_op_dest and fwd_data (DATA_W) = mem_wb_mux ? mem_mem_data : mem_alu_res, all combinational from the registers.
REQ-018 Without MEM_STAGE_FWD_EN, those ports and their logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-019 The shared package SHALL hold the FSM state encoding, default widths and opcode constants (LW, SW).
REQ-020 One sub-module, mem_req_fsm (state, dmem_req/we, stall_o), is natural; the datapath registers SHALL stay in mem_stage_pipe.

Verification
REQ-021 ALU op 0x1234, dest 5, wb_en=1 -> next cycle mem_valid=1, mem_alu_res=0x1234, mem_op_dest=5, stall_o never 1.
REQ-022 Load addr 0x0040, ack 3 cycles after req with rdata 0xBEEF -> stall_o=1 for 4 cycles, then mem_mem_data=0xBEEF, mem_valid=1 for 1 cycle.
REQ-023 Store addr 0x0010 data 0xA5A5 -> dmem_we=1 with addr/wdata stable until ack; completion has mem_wb_en=0.
REQ-024 Load, then ALU op held during stall -> ALU op output exactly one cycle after load result, no loss or duplication.
REQ-025 rst_n low in the second ACCESS cycle -> dmem_req=0 and outputs 0 immediately; after release, a new ALU op completes in 1 cycle.
REQ-026 With MEM_STAGE_FWD_EN, load result 0x00FF, wb_mux=1, dest 2 -> fwd_valid=1, fwd_dest=2, fwd_data=0x00FF.

Source files
------------

// File: rtl/mem_stage_pipe_pkg.sv
// mem_stage_pipe_pkg: shared widths, FSM state encoding and opcode constants for the MEM stage
package mem_stage_pipe_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int DEST_W_DEF = 3;
   localparam int OPC_W_DEF  = 4;
   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;
   localparam logic [OPC_W_DEF-1:0] OPC_LW = 4'h3;
   localparam logic [OPC_W_DEF-1:0] OPC_SW = 4'h4;
endpackage

// File: rtl/mem_req_fsm.sv
// mem_req_fsm: IDLE/ACCESS sequencer owning the dmem request, write select and upstream stall
module mem_req_fsm
   import mem_stage_pipe_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic ex_valid,
   input  logic ex_mem_rd,
   input  logic ex_mem_wr,
   input  logic dmem_ack,
   output logic start,
   output logic done,
   output logic stall_o,
   output logic dmem_req,
   output logic dmem_we
);
   logic [0:0] state;
   assign start    = (state == IDLE) & ex_valid & (ex_mem_rd | ex_mem_wr);
   assign done     = (state == ACCESS) & dmem_ack;
   assign stall_o  = state == ACCESS;
   assign dmem_req = stall_o;
   // a request with both rd and wr set is treated as a store
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         dmem_we <= 1'b0;
      end else if (start) begin
         state   <= ACCESS;
         dmem_we <= ex_mem_wr;
      end else if (done) begin
         state   <= IDLE;
      end
   end
endmodule

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: MEM stage with a blocking dmem handshake; define MEM_STAGE_FWD_EN for forwarding outputs
module mem_stage_pipe
   import mem_stage_pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEST_W = DEST_W_DEF,
   parameter int OPC_W  = OPC_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic [OPC_W-1:0]  ex_opcode,
   input  logic [DATA_W-1:0] ex_alu_res,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [DEST_W-1:0] ex_op_dest,
   input  logic              ex_mem_rd,
   input  logic              ex_mem_wr,
   input  logic              ex_wb_mux,
   input  logic              ex_wb_en,
   output logic              stall_o,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              mem_valid,
   output logic              mem_wb_mux,
   output logic              mem_wb_en,
   output logic [DEST_W-1:0] mem_op_dest,
   output logic [DATA_W-1:0] mem_alu_res,
   output logic [DATA_W-1:0] mem_mem_data,
   output logic [OPC_W-1:0]  opcode_mem_wb
`ifdef MEM_STAGE_FWD_EN
   ,
   output logic              fwd_valid,
   output logic [DEST_W-1:0] fwd_dest,
   output logic [DATA_W-1:0] fwd_data
`endif
);
   logic start, done, alu_go;
   logic [OPC_W-1:0]  cap_opcode;
   logic [DEST_W-1:0] cap_dest;
   logic cap_wb_mux, cap_wb_en;
   mem_req_fsm u_fsm (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_mem_rd(ex_mem_rd),
      .ex_mem_wr(ex_mem_wr), .dmem_ack(dmem_ack), .start(start), .done(done),
      .stall_o(stall_o), .dmem_req(dmem_req), .dmem_we(dmem_we)
   );
   assign alu_go = ~stall_o & ex_valid & ~(ex_mem_rd | ex_mem_wr);
   // dmem_addr/dmem_wdata double as the captured bundle so they stay stable until ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_opcode    <= '0;
         cap_dest      <= '0;
         cap_wb_mux    <= 1'b0;
         cap_wb_en     <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         mem_valid     <= 1'b0;
         mem_wb_mux    <= 1'b0;
         mem_wb_en     <= 1'b0;
         mem_op_dest   <= '0;
         mem_alu_res   <= '0;
         mem_mem_data  <= '0;
         opcode_mem_wb <= '0;
      end else begin
         if (start) begin
            cap_opcode <= ex_opcode;
            cap_dest   <= ex_op_dest;
            cap_wb_mux <= ex_wb_mux;
            cap_wb_en  <= ex_wb_en;
            dmem_addr  <= ex_alu_res;
            dmem_wdata <= ex_store_data;
         end
         mem_valid <= alu_go | done;
         if (alu_go) begin
            opcode_mem_wb <= ex_opcode;
            mem_alu_res   <= ex_alu_res;
            mem_op_dest   <= ex_op_dest;
            mem_wb_mux    <= ex_wb_mux;
            mem_wb_en     <= ex_wb_en;
            mem_mem_data  <= '0;
         end else if (done) begin
            opcode_mem_wb <= cap_opcode;
            mem_alu_res   <= dmem_addr;
            mem_op_dest   <= cap_dest;
            mem_wb_mux    <= cap_wb_mux;
            mem_wb_en     <= ~dmem_we & cap_wb_en;
            mem_mem_data  <= dmem_we ? '0 : dmem_rdata;
         end else begin
            mem_wb_en     <= 1'b0;
         end
      end
   end
`ifdef MEM_STAGE_FWD_EN
   assign fwd_valid = mem_valid & mem_wb_en;
   assign fwd_dest  = mem_op_dest;
   assign fwd_data  = mem_wb_mux ? mem_mem_data : mem_alu_res;
`endif
endmodule
